// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and the status-flag bundle for alu_mdu.
package alu_pkg;

    localparam logic [4:0] ALU_ADDU = 5'h00;
    localparam logic [4:0] ALU_SUBU = 5'h01;
    localparam logic [4:0] ALU_ADD  = 5'h02;
    localparam logic [4:0] ALU_SUB  = 5'h03;
    localparam logic [4:0] ALU_AND  = 5'h04;
    localparam logic [4:0] ALU_OR   = 5'h05;
    localparam logic [4:0] ALU_XOR  = 5'h06;
    localparam logic [4:0] ALU_NOR  = 5'h07;
    localparam logic [4:0] ALU_LUI  = 5'h08;
    localparam logic [4:0] ALU_LUI2 = 5'h09;
    localparam logic [4:0] ALU_SLTU = 5'h0A;
    localparam logic [4:0] ALU_SLT  = 5'h0B;
    localparam logic [4:0] ALU_SRA  = 5'h0C;
    localparam logic [4:0] ALU_SRL  = 5'h0D;
    localparam logic [4:0] ALU_SLL  = 5'h0E;
    localparam logic [4:0] ALU_SLL2 = 5'h0F;
    localparam logic [4:0] ALU_MULU = 5'h10;
    localparam logic [4:0] ALU_MUL  = 5'h11;
    localparam logic [4:0] ALU_DIVU = 5'h12;
    localparam logic [4:0] ALU_DIV  = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
        logic div_by_zero;
    } flags_t;

endpackage

// File: rtl/mul_div_iter.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// res_lo/res_hi carry the value of the final iteration combinationally while done is high.
module mul_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // hi holds the product high half / partial remainder, lo the multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                hi_n = div_diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        done     = busy_q && (cnt_q == LAST);
        if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = op_a;
            b_d      = op_b;
        end else if (busy_q) begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    assign res_lo = lo_n;
    assign res_hi = hi_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with iterative multiply/divide behind valid/ready handshakes.
// Single-cycle ops (and the divide special cases) bypass the FSM; MUL/DIV go IDLE->CALC->DONE.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] r_hi_q, r_hi_d;
    flags_t           flags_q, flags_d;
    logic             mdu_signed_q, mdu_signed_d;
    logic             mdu_div_q, mdu_div_d;
    logic             q_neg_q, q_neg_d;
    logic             rem_neg_q, rem_neg_d;

    logic             accept;
    logic             retire;

    // Single-cycle ALU datapath
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   sra_ext;
    logic [WIDTH:0]   srl_ext;
    logic [WIDTH:0]   sll_ext;
    logic [SHW-1:0]   shamt;
    logic             lt_u;
    logic             lt_s;
    logic             eq;
    logic [WIDTH-1:0] alu_r;
    flags_t           alu_f;

    logic             div_op;
    logic             div_zero;
    logic             div_ovf;
    logic             iter_op;
    logic [WIDTH-1:0] sc_r;
    logic [WIDTH-1:0] sc_hi;
    flags_t           sc_f;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;

    logic [2*WIDTH-1:0] full_prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   mdu_r;
    logic [WIDTH-1:0]   mdu_hi;
    flags_t             mdu_f;

    // NOTE: in_ready looks at out_ready combinationally so a retire and an accept can share an edge.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid_q && out_ready;

    always_comb begin
        shamt   = a[SHW-1:0];
        add_ext = {1'b0, a} + {1'b0, b};
        sub_ext = {1'b0, a} - {1'b0, b};
        lt_u    = sub_ext[WIDTH];
        lt_s    = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sub_ext[WIDTH-1];
        eq      = (a == b);
        // A guard bit below/above the operand catches the last bit shifted out.
        sra_ext = $signed({b, 1'b0}) >>> shamt;
        srl_ext = {b, 1'b0} >> shamt;
        sll_ext = {1'b0, b} << shamt;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        alu_r = '0;
        alu_f = '0;
        case (aluc)
            ALU_ADDU: begin
                alu_r       = add_ext[WIDTH-1:0];
                alu_f.carry = add_ext[WIDTH];
            end
            ALU_SUBU: begin
                alu_r       = sub_ext[WIDTH-1:0];
                alu_f.carry = lt_u;
            end
            ALU_ADD: begin
                alu_r          = add_ext[WIDTH-1:0];
                alu_f.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_r          = sub_ext[WIDTH-1:0];
                alu_f.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:            alu_r = a & b;
            ALU_OR:             alu_r = a | b;
            ALU_XOR:            alu_r = a ^ b;
            ALU_NOR:            alu_r = ~(a | b);
            ALU_LUI, ALU_LUI2:  alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SLTU: begin
                alu_r       = {{(WIDTH-1){1'b0}}, lt_u};
                alu_f.carry = lt_u;
            end
            ALU_SLT:            alu_r = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SRA: begin
                alu_r       = sra_ext[WIDTH:1];
                alu_f.carry = sra_ext[0];
            end
            ALU_SRL: begin
                alu_r       = srl_ext[WIDTH:1];
                alu_f.carry = srl_ext[0];
            end
            ALU_SLL, ALU_SLL2: begin
                alu_r       = sll_ext[WIDTH-1:0];
                alu_f.carry = sll_ext[WIDTH];
            end
            default: ;
        endcase
        if (aluc == ALU_SLT) begin
            alu_f.zero     = eq;
            alu_f.negative = lt_s;
        end else if (aluc == ALU_SLTU) begin
            alu_f.zero     = eq;
        end else begin
            alu_f.zero     = (alu_r == '0);
            alu_f.negative = alu_r[WIDTH-1];
        end
    end

    // Divide special cases finish in one cycle; DIV flags follow the zero/negative rule on r.
    always_comb begin
        div_op   = (aluc == ALU_DIVU) || (aluc == ALU_DIV);
        div_zero = div_op && (b == '0);
        div_ovf  = (aluc == ALU_DIV) && (a == MIN_VAL) && (b == '1);
        iter_op  = (aluc == ALU_MULU) || (aluc == ALU_MUL) || (div_op && !div_zero && !div_ovf);
        sc_r     = alu_r;
        sc_hi    = '0;
        sc_f     = alu_f;
        if (aluc[4]) begin
            sc_r = '0;
            sc_f = '0;
            if (div_zero) begin
                sc_r             = '1;
                sc_hi            = a;
                sc_f.div_by_zero = 1'b1;
                sc_f.negative    = 1'b1;
            end else if (div_ovf) begin
                sc_r          = MIN_VAL;
                sc_f.overflow = 1'b1;
                sc_f.negative = 1'b1;
            end
        end
    end

    always_comb begin
        a_neg = aluc[0] && a[WIDTH-1];
        b_neg = aluc[0] && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    mul_div_iter #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .is_div (aluc[1]),
        .op_a   (a_mag),
        .op_b   (b_mag),
        .done   (eng_done),
        .res_lo (eng_lo),
        .res_hi (eng_hi)
    );

    // Sign fix-up on the engine's final-iteration value, loaded on the CALC->DONE edge.
    always_comb begin
        full_prod = {eng_hi, eng_lo};
        prod_fix  = q_neg_q ? -full_prod : full_prod;
        quo_fix   = q_neg_q ? -eng_lo : eng_lo;
        rem_fix   = rem_neg_q ? -eng_hi : eng_hi;
        mdu_f     = '0;
        if (mdu_div_q) begin
            mdu_r          = quo_fix;
            mdu_hi         = rem_fix;
            mdu_f.zero     = (quo_fix == '0);
            mdu_f.negative = quo_fix[WIDTH-1];
        end else begin
            mdu_r          = prod_fix[WIDTH-1:0];
            mdu_hi         = prod_fix[2*WIDTH-1:WIDTH];
            mdu_f.zero     = (prod_fix == '0);
            mdu_f.negative = mdu_signed_q && prod_fix[2*WIDTH-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        r_d          = r_q;
        r_hi_d       = r_hi_q;
        flags_d      = flags_q;
        mdu_signed_d = mdu_signed_q;
        mdu_div_d    = mdu_div_q;
        q_neg_d      = q_neg_q;
        rem_neg_d    = rem_neg_q;
        eng_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (iter_op) begin
                        eng_start    = 1'b1;
                        state_d      = ST_CALC;
                        out_valid_d  = 1'b0;
                        mdu_signed_d = aluc[0];
                        mdu_div_d    = aluc[1];
                        q_neg_d      = a_neg ^ b_neg;
                        rem_neg_d    = a_neg;
                    end else begin
                        out_valid_d = 1'b1;
                        r_d         = sc_r;
                        r_hi_d      = sc_hi;
                        flags_d     = sc_f;
                    end
                end else if (retire) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_CALC: begin
                if (eng_done) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    r_d         = mdu_r;
                    r_hi_d      = mdu_hi;
                    flags_d     = mdu_f;
                end
            end
            ST_DONE: begin
                if (retire) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: result registers are reset along with the control state so r/r_hi/flags read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            r_q          <= '0;
            r_hi_q       <= '0;
            flags_q      <= '0;
            mdu_signed_q <= 1'b0;
            mdu_div_q    <= 1'b0;
            q_neg_q      <= 1'b0;
            rem_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            r_q          <= r_d;
            r_hi_q       <= r_hi_d;
            flags_q      <= flags_d;
            mdu_signed_q <= mdu_signed_d;
            mdu_div_q    <= mdu_div_d;
            q_neg_q      <= q_neg_d;
            rem_neg_q    <= rem_neg_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign r           = r_q;
    assign r_hi        = r_hi_q;
    assign zero        = flags_q.zero;
    assign carry       = flags_q.carry;
    assign negative    = flags_q.negative;
    assign overflow    = flags_q.overflow;
    assign div_by_zero = flags_q.div_by_zero;

endmodule
